// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// helper that sizes the bit counter from the operand width.
package serial_adder_pkg;

   // The encoding 2'd3 is unused; the FSM treats it as illegal and returns to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bits needed to count 0..w-1, never less than one.
   function automatic int cnt_width(input int w);
      if (w <= 2) return 1;
      return $clog2(w);
   endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational one-bit full adder made of two half-adder stages and an OR.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic w_s1;
   logic w_c1;
   logic w_c2;

   assign w_s1 = a ^ b;
   assign w_c1 = a & b;
   assign sum  = w_s1 ^ cin;
   assign w_c2 = w_s1 & cin;
   assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first through one full-adder cell, valid/ready on both sides.
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic [WIDTH-1:0] r_sum_sh;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             w_s;
   logic             w_c;
   logic             w_last;

   assign w_last = (r_cnt == LAST);

   full_adder_bit u_fa (
      .a    (r_sh_a[0]),
      .b    (r_sh_b[0]),
      .cin  (r_carry),
      .sum  (w_s),
      .cout (w_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Operands are taken only in IDLE; in_ready and out_valid are mutually exclusive by state.
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = ST_RUN;
         end
         ST_RUN: begin
            if (w_last) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
      busy = (r_state != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_a   <= '0;
         r_sh_b   <= '0;
         r_sum_sh <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
      end else if (r_state == ST_IDLE && in_valid) begin
         r_sh_a   <= a;
         r_sh_b   <= b;
         r_sum_sh <= '0;
         r_carry  <= cin;
         r_cnt    <= '0;
      end else if (r_state == ST_RUN) begin
         r_sh_a   <= r_sh_a >> 1;
         r_sh_b   <= r_sh_b >> 1;
         r_sum_sh <= (r_sum_sh >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
         r_carry  <= w_c;
         // Parking at zero keeps WIDTH=1 (and non-power-of-two widths) from wrapping.
         r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   assign sum  = r_sum_sh;
   assign cout = r_carry;

`ifdef SERIAL_ADDER_OVF_EN
   logic r_carry_msb;

   // On the final RUN cycle r_carry is the carry into the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_carry_msb <= 1'b0;
      else if (r_state == ST_RUN && w_last) r_carry_msb <= r_carry;
   end

   assign ovf = r_carry_msb ^ r_carry;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=1 instances on one clock.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, cout8, busy8, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, sum8;
   logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, cout1, busy1, cin1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0, sum1;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf8, ovf1;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .busy(busy8)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .busy(busy1)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf1)
`endif
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands to the 8-bit instance and return once they are accepted.
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int n;
      n = 0;
      while (!in_ready8 && n < 50) begin
         tick();
         n++;
      end
      check("send8_ready", in_ready8, 1'b1);
      a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
   endtask

   // Count edges after accept until out_valid rises (bounded).
   task automatic wait_done8(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid8 && lat < 40);
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec);
      int lat;
      send8(a, b, c);
      wait_done8(lat);
      check({tag, "_lat"}, lat, 8);
      check({tag, "_sum"}, sum8, es);
      check({tag, "_cout"}, cout8, ec);
      tick();
      check({tag, "_ovdrop"}, out_valid8, 1'b0);
   endtask

   initial begin
      logic [7:0] fa_sum_tab;
      logic [7:0] fa_cout_tab;
      int         last_acc;
      int         n;

      // Reset values while rst_n is held low.
      #2;
      check("rst_in_ready", in_ready8, 1'b1);
      check("rst_out_valid", out_valid8, 1'b0);
      check("rst_busy", busy8, 1'b0);
      check("rst_sum", sum8, 8'h00);
      check("rst_cout", cout8, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf", ovf8, 1'b0);
`endif
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      op8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      op8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      op8("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
      op8("add_80_7f", 8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0);

      // Backpressure: result held for 5 cycles while fresh operands are offered.
      begin
         int lat;
         out_ready8 = 1'b0;
         send8(8'h12, 8'h34, 1'b0);
         check("bp_busy_run", busy8, 1'b1);
         wait_done8(lat);
         check("bp_lat", lat, 8);
         for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1;
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            cin8 = 1'($urandom_range(0, 1));
            tick();
            check("bp_out_valid", out_valid8, 1'b1);
            check("bp_in_ready", in_ready8, 1'b0);
            check("bp_sum", sum8, 8'h46);
            check("bp_cout", cout8, 1'b0);
         end
         in_valid8 = 1'b0;
         out_ready8 = 1'b1;
         tick();
         check("bp_release", out_valid8, 1'b0);
         check("bp_idle", in_ready8, 1'b1);
      end

      // Reset during RUN aborts immediately.
      send8(8'h5A, 8'h3C, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid8, 1'b0);
      check("mid_rst_in_ready", in_ready8, 1'b1);
      check("mid_rst_sum", sum8, 8'h00);
      check("mid_rst_busy", busy8, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      op8("post_rst_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
      op8("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
      check("ovf_7f_01_ovf", ovf8, 1'b1);
      op8("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
      check("ovf_80_80_ovf", ovf8, 1'b1);
      op8("ovf_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
      check("ovf_10_20_ovf", ovf8, 1'b0);
`endif

      // WIDTH=1: full-adder truth table, index = {a,b,cin}.
      fa_sum_tab  = 8'b1001_0110;
      fa_cout_tab = 8'b1110_1000;
      last_acc = 0;
      for (int v = 0; v < 8; v++) begin
         n = 0;
         while (!in_ready1 && n < 20) begin
            tick();
            n++;
         end
         check("w1_ready", in_ready1, 1'b1);
         a1 = 1'(v >> 2); b1 = 1'(v >> 1); cin1 = 1'(v); in_valid1 = 1'b1;
         tick();
         in_valid1 = 1'b0;
         if (v > 0) check("w1_spacing", cyc - last_acc, 3);
         last_acc = cyc;
         tick();
         check("w1_out_valid", out_valid1, 1'b1);
         check("w1_sum", sum1, fa_sum_tab[v]);
         check("w1_cout", cout1, fa_cout_tab[v]);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
